// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side schedulers.
package fifo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or above rr_ptr_i, wrapping past num_p-1.
module rr_picker #(
  parameter int num_p = 4
) (
  input  logic [num_p-1:0]         req_i,
  input  logic [$clog2(num_p)-1:0] rr_ptr_i,
  output logic [$clog2(num_p)-1:0] winner_o,
  output logic                     any_o
);

  localparam int idx_w = $clog2(num_p);

  logic [idx_w:0] sum_s;
  logic [idx_w:0] idx_s;

  // Scan candidates in priority order; the first hit wins.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    sum_s    = '0;
    idx_s    = '0;
    for (int i = 0; i < num_p; i++) begin
      sum_s = {1'b0, rr_ptr_i} + (idx_w+1)'(i);
      idx_s = (sum_s >= (idx_w+1)'(num_p)) ? (sum_s - (idx_w+1)'(num_p)) : sum_s;
      if (!any_o && req_i[idx_s[idx_w-1:0]]) begin
        any_o    = 1'b1;
        winner_o = idx_s[idx_w-1:0];
      end else begin
        any_o    = any_o;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging num_p requesters onto one FIFO write port.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int width_p = 8,
  parameter int num_p   = 4,
  parameter int burst_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [num_p-1:0]           valid_i,
  input  logic [num_p*width_p-1:0]   data_i,
  output logic [num_p-1:0]           ready_o,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(num_p)-1:0]   id_o,
  input  logic                       ready_i
);

  localparam int idx_w = $clog2(num_p);
  localparam int cnt_w = $clog2(burst_p+1);

  state_e             state_q, state_d;
  logic [idx_w-1:0]   rr_ptr_q, rr_ptr_d;
  logic [idx_w-1:0]   grant_q, grant_d;
  logic [cnt_w-1:0]   beat_cnt_q, beat_cnt_d;

  logic [idx_w-1:0]   winner_s;
  logic               any_s;
  logic [idx_w-1:0]   grant_next_s;
  logic               gnt_valid_s;
  logic               last_beat_s;

  rr_picker #(.num_p(num_p)) u_picker (
    .req_i    (valid_i),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (winner_s),
    .any_o    (any_s)
  );

  assign grant_next_s = (grant_q == idx_w'(num_p-1)) ? '0 : (grant_q + idx_w'(1));
  assign gnt_valid_s  = valid_i[grant_q];
  assign last_beat_s  = (beat_cnt_q == cnt_w'(burst_p-1));

  // Output mux: pass the granted requester straight through during a burst.
  always_comb begin
    ready_o = '0;
    valid_o = 1'b0;
    data_o  = '0;
    id_o    = '0;
    case (state_q)
      BURST: begin
        ready_o[grant_q] = ready_i;
        valid_o          = gnt_valid_s;
        data_o           = data_i[grant_q*width_p +: width_p];
        id_o             = grant_q;
      end
      default: begin
        ready_o = '0;
      end
    endcase
  end

  // Next-state: arbitration in IDLE, beat counting and release in BURST.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d    = BURST;
          grant_d    = winner_s;
          beat_cnt_d = '0;
        end else begin
          state_d    = IDLE;
        end
      end
      BURST: begin
        if (!gnt_valid_s) begin
          state_d    = IDLE;
          rr_ptr_d   = grant_next_s;
          beat_cnt_d = '0;
        end else if (ready_i) begin
          if (last_beat_s) begin
            state_d    = IDLE;
            rr_ptr_d   = grant_next_s;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + cnt_w'(1);
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: queued requester sources, expected-beat queue, FIFO-side monitor.
module tb_fifo_wr_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N-1:0]   valid_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ready_o;
  logic           valid_o;
  logic [W-1:0]   data_o;
  logic [1:0]     id_o;
  logic           ready_i;

  logic           reset_b;
  logic [2:0]     valid_b;
  logic [23:0]    data_b;
  logic [2:0]     ready_b_o;
  logic           valid_b_o;
  logic [7:0]     data_b_o;
  logic [1:0]     id_b_o;
  logic           ready_b_i;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.width_p(W), .num_p(N), .burst_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .id_o(id_o),
    .ready_i(ready_i)
  );

  fifo_wr_arbiter #(.width_p(8), .num_p(3), .burst_p(4)) dut_b (
    .clk_i(clk), .reset_i(reset_b), .valid_i(valid_b), .data_i(data_b),
    .ready_o(ready_b_o), .valid_o(valid_b_o), .data_o(data_b_o), .id_o(id_b_o),
    .ready_i(ready_b_i)
  );

  logic [7:0] src_data [N][16];
  int         src_cnt  [N];
  int         src_head [N];
  logic [N-1:0] fire;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [9:0] exp_q [$];
  int         xfer_cyc [$];

  // Each source presents its next queued word until it is accepted.
  always_comb begin
    valid_i = '0;
    data_i  = '0;
    for (int k = 0; k < N; k++) begin
      if (src_head[k] < src_cnt[k]) begin
        valid_i[k]         = 1'b1;
        data_i[k*W +: W]   = src_data[k][src_head[k][3:0]];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Source pop: a word leaves its source only when accepted outside reset.
  always begin
    @(negedge clk);
    fire = valid_i & ready_o;
    @(posedge clk);
    #1;
    if (!reset_i) begin
      for (int k = 0; k < N; k++) if (fire[k]) src_head[k] = src_head[k] + 1;
    end
  end

  // FIFO-side monitor: every accepted beat must match the next expected one.
  always begin
    logic [9:0] e;
    @(negedge clk);
    if (!reset_i && valid_o && ready_i) begin
      xfer_cyc.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got id %0d data %h, expected no beat", id_o, data_o);
      end else begin
        e = exp_q.pop_front();
        if ({id_o, data_o} !== e || ready_o !== (4'b0001 << e[9:8])) begin
          n_err++;
          $display("FAIL beat: got id %0d data %h ready %b, expected id %0d data %h ready %b",
                   id_o, data_o, ready_o, e[9:8], e[7:0], 4'b0001 << e[9:8]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int k, input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++) src_data[k][b] = base + 8'(b);
    src_head[k] = 0;
    src_cnt[k]  = n;
  endtask

  task automatic push(input int k, input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back({2'(k), base + 8'(b)});
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  task automatic wait_head(input int k, input int n, input int limit);
    int t = 0;
    while (src_head[k] < n && t < limit) begin
      tick();
      t++;
    end
    if (src_head[k] < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL head_timeout: got %0d accepted on req %0d, expected %0d", src_head[k], k, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    reset_i = 1'b1; ready_i = 1'b1;
    reset_b = 1'b1; valid_b = 3'b000; data_b = 24'h000000; ready_b_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      src_cnt[k]  = 0;
      src_head[k] = 0;
    end
    repeat (2) tick();
    reset_i = 1'b0;

    // Reset and idle: outputs stay zero with no requests.
    repeat (10) begin
      @(negedge clk);
      check("idle_outputs", {valid_o, ready_o, id_o, data_o}, 32'h0);
    end
    tick();

    // Fairness: all requesters busy, grants rotate 0..3 in 4-beat bursts.
    s = xfer_cyc.size();
    for (int k = 0; k < N; k++) load(k, 8'(8'h10 * k), 5);
    for (int k = 0; k < N; k++) push(k, 8'(8'h10 * k), 4);
    for (int k = 0; k < N; k++) push(k, 8'(8'h10 * k + 4), 1);
    wait_drain(300);
    for (int i = 1; i < 16; i++)
      check("burst_timing", 32'(xfer_cyc[s+i] - xfer_cyc[s]), 32'(i + i/4));

    // Early release: requester 2 sends two beats, pointer moves to 3.
    load(2, 8'h50, 2);
    push(2, 8'h50, 2);
    wait_drain(100);
    load(0, 8'h60, 1);
    load(3, 8'h70, 1);
    push(3, 8'h70, 1);
    push(0, 8'h60, 1);
    wait_drain(100);

    // Back-pressure at beat 1 holds the grant and data.
    load(1, 8'hB0, 4);
    push(1, 8'hB0, 4);
    wait_head(1, 1, 50);
    ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {valid_o, id_o, ready_o, data_o}, {1'b1, 2'd1, 4'b0000, 8'hB1});
    end
    tick();
    ready_i = 1'b1;
    wait_drain(100);

    // Reset during beat 2 of requester 3 abandons the burst and clears rr_ptr.
    load(3, 8'hC0, 4);
    push(3, 8'hC0, 2);
    wait_head(3, 2, 50);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    load(1, 8'hD0, 2);
    push(1, 8'hD0, 2);
    push(3, 8'hC2, 2);
    @(negedge clk);
    check("reset_idle", {valid_o, ready_o, id_o, data_o}, 32'h0);
    wait_drain(100);

    // Wrap on num_p=3: requester 2 granted, then pointer wraps to 0.
    tick();
    reset_b = 1'b0;
    valid_b = 3'b100;
    data_b  = {8'hA2, 8'hA1, 8'hA0};
    @(negedge clk);
    check("wrap_idle0", {valid_b_o, id_b_o, ready_b_o, data_b_o}, 32'h0);
    @(negedge clk);
    check("wrap_grant2", {valid_b_o, id_b_o, ready_b_o, data_b_o}, {1'b1, 2'd2, 3'b100, 8'hA2});
    tick();
    valid_b = 3'b011;
    @(posedge clk);
    @(negedge clk);
    check("wrap_idle1", {valid_b_o, id_b_o, ready_b_o, data_b_o}, 32'h0);
    @(negedge clk);
    check("wrap_grant0", {valid_b_o, id_b_o, ready_b_o, data_b_o}, {1'b1, 2'd0, 3'b001, 8'hA0});
    tick();
    valid_b = 3'b000;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
